raster_scheduler: RTL

RASTER_SCHEDULER -- requirements
Module: raster_scheduler

---
 rtl/raster_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/raster_scheduler.sv
// Raster scheduler: walks a triangle's bounding box, issues pixels to the
// barycentric unit and re-tags the in-order results with their coordinates.
module raster_scheduler #(
    parameter int TAG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_nd,
    output logic        tri_rfd,
    input  logic [15:0] v1_x,
    input  logic [15:0] v1_y,
    input  logic [15:0] v2_x,
    input  logic [15:0] v2_y,
    input  logic [15:0] v3_x,
    input  logic [15:0] v3_y,
    input  logic [9:0]  x_min,
    input  logic [9:0]  x_max,
    input  logic [9:0]  y_min,
    input  logic [9:0]  y_max,
    output logic        bc_nd,
    input  logic        bc_us_rfd,
    output logic [15:0] bc_v1_x,
    output logic [15:0] bc_v1_y,
    output logic [15:0] bc_v2_x,
    output logic [15:0] bc_v2_y,
    output logic [15:0] bc_v3_x,
    output logic [15:0] bc_v3_y,
    output logic [15:0] bc_p_x,
    output logic [15:0] bc_p_y,
    output logic        bc_ds_rfd,
    input  logic        bc_rdy,
    input  logic [15:0] bc_b_u,
    input  logic [15:0] bc_b_v,
    input  logic [15:0] bc_b_w,
    output logic        pix_valid,
    input  logic        pix_rfd,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_u,
    output logic [15:0] pix_v,
    output logic [15:0] pix_w,
    output logic        tri_done,
    output logic        busy,
    output logic        tag_err
);

    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        init_q, done_q, done_nxt, err_q;
    logic [9:0]  cx, cy;
    logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q;
    logic [95:0] vtx_q;
    logic [19:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic        full, empty, accept, box_bad;
    logic        push, pop_req, pop, last;

    // Exact integer-to-half conversion; every 10-bit value fits the mantissa.
    function automatic logic [15:0] to_half(input logic [9:0] v);
        logic [3:0]  msb;
        logic [19:0] sh;
        logic [15:0] h;
        msb = '0;
        for (int i = 0; i < 10; i++)
            if (v[i]) msb = 4'(i);
        sh = {10'b0, v} << (5'd10 - {1'b0, msb});
        h = {1'b0, 5'd15 + {1'b0, msb}, sh[9:0]};
        if (v == '0) h = 16'h0000;
        return h;
    endfunction

    assign full    = (count == (AW+1)'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign accept  = tri_nd && tri_rfd;
    assign box_bad = (x_min > x_max) || (y_min > y_max);
    assign push    = bc_nd;
    assign pop_req = bc_rdy && pix_rfd;
    assign pop     = pop_req && !empty;
    assign last    = (cx == xmax_q) && (cy == ymax_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && box_bad)  done_nxt  = 1'b1;
                if (accept && !box_bad) state_nxt = SCAN;
            end
            SCAN:
                if (push && last) state_nxt = DRAIN;
            DRAIN:
                if (empty && !pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tri_rfd = init_q && (state == IDLE);
        bc_nd   = (state == SCAN) && bc_us_rfd && !full;
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cx     <= '0;
            cy     <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            vtx_q  <= '0;
        end else begin
            init_q <= 1'b1;
            done_q <= done_nxt;
            if (pop_req && empty) err_q <= 1'b1;
            if (accept) begin
                vtx_q  <= {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y};
                xmin_q <= x_min;
                xmax_q <= x_max;
                ymin_q <= y_min;
                ymax_q <= y_max;
                cx     <= x_min;
                cy     <= y_min;
            end else if (push) begin
                if (cx < xmax_q) begin
                    cx <= cx + 10'd1;
                end else begin
                    cx <= xmin_q;
                    cy <= cy + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= {cx, cy};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {bc_v1_x, bc_v1_y, bc_v2_x, bc_v2_y, bc_v3_x, bc_v3_y} = vtx_q;
    assign bc_p_x    = to_half(cx);
    assign bc_p_y    = to_half(cy);
    assign bc_ds_rfd = pix_rfd;
    assign pix_valid = bc_rdy;
    assign pix_u     = bc_b_u;
    assign pix_v     = bc_b_v;
    assign pix_w     = bc_b_w;
    assign {pix_x, pix_y} = tag_mem[rd_ptr];
    assign tri_done  = done_q;
    assign tag_err   = err_q;

endmodule
